// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: requester handshakes, shared response word and memory-side signals of
// imem_arbiter. The arbiter uses the slave modport; fetch/debug/memory side uses master.
interface imem_arbiter_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 32
);
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rsp_valid;
   logic              f_rsp_ready;

   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_gnt;
   logic              d_rsp_valid;
   logic              d_rsp_ready;

   logic [DATA_W-1:0] rsp_data;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              busy;

   modport master (
      output f_req, f_addr, f_rsp_ready,
      output d_req, d_addr, d_rsp_ready,
      output mem_data,
      input  f_gnt, f_rsp_valid, d_gnt, d_rsp_valid,
      input  rsp_data, mem_addr, busy
   );

   modport slave (
      input  f_req, f_addr, f_rsp_ready,
      input  d_req, d_addr, d_rsp_ready,
      input  mem_data,
      output f_gnt, f_rsp_valid, d_gnt, d_rsp_valid,
      output rsp_data, mem_addr, busy
   );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the synchronous-read instructionmemory port between fetch (F) and
// debug (D), one read in flight. Define IMEM_ARB_STARVE_EN to bound how long D can lose to F.
module imem_arbiter #(
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           rst,
   imem_arbiter_if.slave bus
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRead = 2'd1;
   localparam logic [1:0] StResp = 2'd2;

   logic [1:0]        state_q, state_d;
   logic              owner_q, owner_d;
   logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic              any_req;
   logic              handshake;
   logic              decide;
   logic              win_d;
   logic [ADDR_W-1:0] win_addr;

   assign any_req   = bus.f_req | bus.d_req;
   assign handshake = (state_q == StResp) & (owner_q ? bus.d_rsp_ready : bus.f_rsp_ready);
   // Gated by rst so no grant or issued address leaks out while reset is held.
   assign decide    = ~rst & any_req & ((state_q == StIdle) | handshake);
   assign win_addr  = win_d ? bus.d_addr : bus.f_addr;

`ifdef IMEM_ARB_STARVE_EN
   logic [3:0] starve_q, starve_d;

   assign win_d = bus.d_req & (~bus.f_req | (starve_q == 4'(STARVE_LIMIT)));

   always_comb begin
      starve_d = starve_q;
      if (decide && bus.d_req) begin
         starve_d = win_d ? 4'd0 : starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   logic unused_starve_limit;

   assign unused_starve_limit = ^(4'(STARVE_LIMIT));
   assign win_d = bus.d_req & ~bus.f_req;
`endif

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      addr_hold_d = addr_hold_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         StRead: begin
            rsp_data_d = bus.mem_data;
            state_d    = StResp;
         end
         StResp: begin
            if (handshake) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // A decision (from IDLE or a RESP handshake) always overrides the plain transition.
      if (decide) begin
         state_d     = StRead;
         owner_d     = win_d;
         addr_hold_d = win_addr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         owner_q     <= 1'b0;
         addr_hold_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         addr_hold_q <= addr_hold_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign bus.f_gnt       = decide & ~win_d;
   assign bus.d_gnt       = decide & win_d;
   assign bus.f_rsp_valid = (state_q == StResp) & ~owner_q;
   assign bus.d_rsp_valid = (state_q == StResp) & owner_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.mem_addr    = decide ? win_addr : addr_hold_q;
   assign bus.busy        = (state_q != StIdle);

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Two-port arbiter and sequencer for the synchronous-read `instructionmemory`. It shares the single read port between the fetch stage (port F) and the debug/program-inspection port (port D). It issues one read at a time, captures the returned word, and holds it for the owning requester under a valid/ready handshake. It sits between the fetch/debug logic and `instructionmemory`, and drives that block's `addr` input.

## Interface
Parameters:
- `ADDR_W`, 11, word address width; matches `instructionmemory.addr`.
- `DATA_W`, 32, instruction word width.
- `STARVE_LIMIT`, 4, consecutive lost D arbitrations before D is forced to win (used only when `IMEM_ARB_STARVE_EN` is defined); legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `f_req`  in  1  fetch read request; held with `f_addr` stable until `f_gnt`.
- `f_addr`  in  ADDR_W  fetch word address.
- `f_gnt`  out  1  one-cycle pulse: request accepted this cycle.
- `f_rsp_valid`  out  1  `rsp_data` holds the fetch result.
- `f_rsp_ready`  in  1  fetch consumes the response.
- `d_req`, `d_addr`, `d_gnt`, `d_rsp_valid`, `d_rsp_ready`: same as the F port, for debug.
- `rsp_data`  out  DATA_W  captured memory word, shared by both ports.
- `mem_addr`  out  ADDR_W  to `instructionmemory.addr`.
- `mem_data`  in  DATA_W  from `instructionmemory.data_out`; valid the cycle after the address is sampled.
- `busy`  out  1  state ≠ IDLE.

## Operation
The FSM has three states: IDLE, READ, RESP. An `owner` register is 0 for F and 1 for D.

- **Arbitration decision:** taken in IDLE, and in RESP on the handshake cycle, whenever `f_req|d_req`.
  - Default policy: F beats D.
  - The winner's `*_gnt` pulses.
  - `mem_addr` is driven combinationally from the winner's address.
  - `owner` and `addr_hold` are latched.
  - Next state is READ.
- **IDLE:** no request → stay.
- **READ:** `mem_data` is valid. Capture it into `rsp_data` at the clock edge, then go to RESP. No grant is issued in READ.
- **RESP:**
  - `f_rsp_valid = (owner==0)`, `d_rsp_valid = (owner==1)`.
  - The handshake completes when the owner's `*_rsp_ready` is 1.
  - On handshake with a request pending, re-arbitrate in the same cycle and go to READ.
  - On handshake with no request pending, go to IDLE.
  - The non-owner's `*_rsp_ready` is ignored.
  - Without a handshake, stay; `rsp_data` and valid are held stable.
- **`mem_addr` when not issuing:** equals `addr_hold`, the last issued address (0 after reset).
- Only one read is in flight at any time. A requester may deassert `req` after its `gnt`. A `req` dropped before `gnt` is simply not served.
- A requester may assert `req` for a new read while its own response is still pending. That request is arbitrated in the handshake cycle.
- No address range check is done; all `2^ADDR_W` addresses are passed through.

## Timing
- **Reset (async):**
  - State IDLE, `owner` 0, `addr_hold` 0, `rsp_data` 0, starve counter 0.
  - All `*_gnt`, `*_rsp_valid` and `busy` are 0; `mem_addr` is 0.
  - An in-flight read is discarded and no response is produced.
- **Latency:** grant in cycle N, `*_rsp_valid` rises in cycle N+2.
- **Throughput:** with `rsp_ready` tied high, back-to-back requests are served at one read per 2 cycles (grants in N, N+2, N+4, …).
- **Simultaneous `f_req` and `d_req`:** exactly one grant per decision, never both.
- **Reset deasserting with `req` already high:** the first grant occurs in the first cycle after release.

## Configuration
- **`IMEM_ARB_STARVE_EN` defined:**
  - A 4-bit counter increments on every decision where `d_req` = 1 and F wins.
  - When the counter equals `STARVE_LIMIT`, the next decision with `d_req` = 1 grants D regardless of `f_req`.
  - The counter clears on any D grant.
  - The counter does not change on decisions where `d_req` = 0.
- **Not defined:** strict F priority; D can starve indefinitely. The counter logic is absent.

## Test plan
- **Single fetch:** preloaded mem[5]=0x2402000A; pulse `f_req` with `f_addr`=5, `f_rsp_ready`=1 → `f_gnt` in cycle N, `f_rsp_valid` with `rsp_data`=0x2402000A in N+2, `d_rsp_valid` stays 0.
- **Contention:** `f_req`=`d_req`=1 in the same cycle, `f_addr`=3, `d_addr`=7 → F granted first (`mem_addr`=3), D granted at the F handshake cycle, D response carries mem[7].
- **Backpressure:** hold `d_rsp_ready`=0 for 5 cycles after `d_rsp_valid` → `rsp_data` and `d_rsp_valid` stable, no new grant; on `d_rsp_ready`=1, a pending `f_req` is granted in the same cycle.
- **Streaming:** `f_req` held high with `f_addr` incrementing on each `f_gnt` from 0 to 9, `f_rsp_ready`=1 → 10 responses mem[0..9] in order, grants every 2 cycles, `d_gnt` never asserted.
- **Starvation, with `IMEM_ARB_STARVE_EN` defined:** `f_req`, `d_req` held high, `STARVE_LIMIT`=4 → grant sequence F,F,F,F,D,F,F,F,F,D. Without the macro → only F grants.
- **Reset mid-read:** assert `rst` during READ → asynchronously `busy`=0, `rsp_data`=0, all valids 0, `mem_addr`=0; after release, no stale response appears.
